alu_4_bit: RTL and testbench

4-bit registered arithmetic/logic unit. Each cycle it takes two 4-bit operands, a carry/borrow-bar input and a 4-bit operation code, and registers a 4-bit result and a carry/borrow-bar flag. It is the datapath primitive for small controllers and teaching cores, driven combinationally by upstream registers or decoders.

---
 rtl/alu_4_bit_pkg.sv | 25 ++
 rtl/alu_4_bit_if.sv | 22 ++
 rtl/alu_4_bit_adder.sv | 23 ++
 rtl/alu_4_bit.sv | 84 ++++++++
 tb/tb_alu_4_bit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/alu_4_bit_pkg.sv
// rtl/alu_4_bit_pkg.sv - width constant and opcode enum for the 4-bit ALU
package alu_4_bit_pkg;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_ADC  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_SBB  = 4'b0011,
        OP_INC  = 4'b0100,
        OP_DEC  = 4'b0101,
        OP_AND  = 4'b0110,
        OP_OR   = 4'b0111,
        OP_XOR  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_NAND = 4'b1010,
        OP_NOR  = 4'b1011,
        OP_XNOR = 4'b1100,
        OP_SHL  = 4'b1101,
        OP_SHR  = 4'b1110,
        OP_PASS = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/alu_4_bit_if.sv
// rtl/alu_4_bit_if.sv - operand/opcode/result bundle between a driver and the ALU
interface alu_4_bit_if;
    import alu_4_bit_pkg::*;

    logic [ALU_WIDTH-1:0] Data_A_In;
    logic [ALU_WIDTH-1:0] Data_B_In;
    logic                 Carry_Borrowb_In;
    logic [3:0]           Operation_Select_In;
    logic [ALU_WIDTH-1:0] Result_Out;
    logic                 Carry_Out;

    modport master (
        output Data_A_In, Data_B_In, Carry_Borrowb_In, Operation_Select_In,
        input  Result_Out, Carry_Out
    );

    modport slave (
        input  Data_A_In, Data_B_In, Carry_Borrowb_In, Operation_Select_In,
        output Result_Out, Carry_Out
    );

endinterface

// File: rtl/alu_4_bit_adder.sv
// rtl/alu_4_bit_adder.sv - ripple-carry adder shared by all arithmetic opcodes
module alu_4_bit_adder
    import alu_4_bit_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] a,
    input  logic [ALU_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [ALU_WIDTH-1:0] sum,
    output logic                 cout
);

    logic [ALU_WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < ALU_WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[ALU_WIDTH];

endmodule

// File: rtl/alu_4_bit.sv
// rtl/alu_4_bit.sv - registered 4-bit ALU, one operation per clock, 1-cycle latency
module alu_4_bit
    import alu_4_bit_pkg::*;
(
    input  logic        Clock_In,
    input  logic        Reset_In,
    alu_4_bit_if.slave  alu
);

    alu_op_e              op;
    logic [ALU_WIDTH-1:0] add_b;
    logic                 add_cin;
    logic [ALU_WIDTH-1:0] add_sum;
    logic                 add_cout;
    logic [ALU_WIDTH-1:0] result_d;
    logic                 carry_d;
    logic [ALU_WIDTH-1:0] result_q;
    logic                 carry_q;

    assign op = alu_op_e'(alu.Operation_Select_In);

    // Subtraction is A + ~B + cin; INC/DEC reuse the adder with constant 1 / all-ones.
    always_comb begin
        add_b   = alu.Data_B_In;
        add_cin = 1'b0;
        case (op)
            OP_ADC:  add_cin = alu.Carry_Borrowb_In;
            OP_SUB:  begin add_b = ~alu.Data_B_In; add_cin = 1'b1; end
            OP_SBB:  begin add_b = ~alu.Data_B_In; add_cin = alu.Carry_Borrowb_In; end
            OP_INC:  add_b = 4'b0001;
            OP_DEC:  add_b = 4'b1111;
            default: ;
        endcase
    end

    alu_4_bit_adder u_adder (
        .a    (alu.Data_A_In),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        unique case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC: begin
                result_d = add_sum;
                carry_d  = add_cout;
            end
            OP_AND:  result_d = alu.Data_A_In & alu.Data_B_In;
            OP_OR:   result_d = alu.Data_A_In | alu.Data_B_In;
            OP_XOR:  result_d = alu.Data_A_In ^ alu.Data_B_In;
            OP_NOT:  result_d = ~alu.Data_A_In;
            OP_NAND: result_d = ~(alu.Data_A_In & alu.Data_B_In);
            OP_NOR:  result_d = ~(alu.Data_A_In | alu.Data_B_In);
            OP_XNOR: result_d = ~(alu.Data_A_In ^ alu.Data_B_In);
            OP_SHL: begin
                result_d = {alu.Data_A_In[ALU_WIDTH-2:0], 1'b0};
                carry_d  = alu.Data_A_In[ALU_WIDTH-1];
            end
            OP_SHR: begin
                result_d = {1'b0, alu.Data_A_In[ALU_WIDTH-1:1]};
                carry_d  = alu.Data_A_In[0];
            end
            OP_PASS: result_d = alu.Data_A_In;
        endcase
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign alu.Result_Out = result_q;
    assign alu.Carry_Out  = carry_q;

endmodule

// File: tb/tb_alu_4_bit.sv
// tb/tb_alu_4_bit.sv - vector table, reset sequences and random scoreboard for alu_4_bit
module tb_alu_4_bit;
    import alu_4_bit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    alu_4_bit_if bus ();

    alu_4_bit dut (
        .Clock_In (clk),
        .Reset_In (rst),
        .alu      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] op;
        logic [3:0] r;
        logic       c;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] r;
        logic       c;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [3:0] ar, input logic ac,
                         input logic [3:0] er, input logic ec);
        n_checks++;
        if (ar !== er || ac !== ec) begin
            n_fail++;
            $display("FAIL %s: got result=%h carry=%b, expected result=%h carry=%b",
                     name, ar, ac, er, ec);
        end
    endtask

    // Independent reference: plain integer arithmetic, no adder reuse.
    task automatic model(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic [3:0] op, output logic [3:0] r, output logic c);
        int ai, bi, ci, s;
        ai = a; bi = b; ci = cin;
        r = '0; c = 1'b0;
        case (op)
            4'h0: begin s = ai + bi;      r = s[3:0]; c = s >= 16; end
            4'h1: begin s = ai + bi + ci; r = s[3:0]; c = s >= 16; end
            4'h2: begin s = ai - bi;      r = s[3:0]; c = ai >= bi; end
            4'h3: begin s = ai - bi - (1 - ci); r = s[3:0]; c = ai >= bi + (1 - ci); end
            4'h4: begin s = ai + 1;       r = s[3:0]; c = ai == 15; end
            4'h5: begin s = ai - 1;       r = s[3:0]; c = ai != 0; end
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: r = a ^ b;
            4'h9: r = ~a;
            4'hA: r = ~(a & b);
            4'hB: r = ~(a | b);
            4'hC: r = ~(a ^ b);
            4'hD: begin s = ai * 2; r = s[3:0]; c = a[3]; end
            4'hE: begin r = 4'(ai / 2); c = a[0]; end
            default: r = a;
        endcase
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic [3:0] op, input logic [3:0] r, input logic c,
                         input string name);
        exp_t e;
        @(negedge clk);
        bus.Data_A_In           = a;
        bus.Data_B_In           = b;
        bus.Carry_Borrowb_In    = cin;
        bus.Operation_Select_In = op;
        e.r = r; e.c = c; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic capture();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: no expected entry queued, got result=%h", bus.Result_Out);
        end else begin
            e = exp_q.pop_front();
            check(e.name, bus.Result_Out, bus.Carry_Out, e.r, e.c);
        end
    endtask

    initial begin
        logic [3:0] ra, rb, rop, er;
        logic       rc, ec;

        vecs.push_back('{4'hF, 4'h1, 1'b0, 4'h0, 4'h0, 1'b1, "add_carry"});
        vecs.push_back('{4'h7, 4'h8, 1'b1, 4'h1, 4'h0, 1'b1, "adc_carry"});
        vecs.push_back('{4'h3, 4'h5, 1'b0, 4'h2, 4'hE, 1'b0, "sub_borrow"});
        vecs.push_back('{4'h5, 4'h3, 1'b0, 4'h2, 4'h2, 1'b1, "sub_noborrow"});
        vecs.push_back('{4'h5, 4'h3, 1'b0, 4'h3, 4'h1, 1'b1, "sbb_cin0"});
        vecs.push_back('{4'hF, 4'h0, 1'b0, 4'h4, 4'h0, 1'b1, "inc_wrap"});
        vecs.push_back('{4'h0, 4'h0, 1'b1, 4'h5, 4'hF, 1'b0, "dec_wrap"});
        vecs.push_back('{4'hC, 4'hA, 1'b1, 4'h6, 4'h8, 1'b0, "and"});
        vecs.push_back('{4'hC, 4'hA, 1'b1, 4'h7, 4'hE, 1'b0, "or"});
        vecs.push_back('{4'hC, 4'hA, 1'b1, 4'h8, 4'h6, 1'b0, "xor"});
        vecs.push_back('{4'hC, 4'hA, 1'b1, 4'hA, 4'h7, 1'b0, "nand"});
        vecs.push_back('{4'hC, 4'hA, 1'b1, 4'hB, 4'h1, 1'b0, "nor"});
        vecs.push_back('{4'hC, 4'hA, 1'b1, 4'hC, 4'h9, 1'b0, "xnor"});
        vecs.push_back('{4'hC, 4'hA, 1'b1, 4'h9, 4'h3, 1'b0, "not"});
        vecs.push_back('{4'hC, 4'hA, 1'b1, 4'hF, 4'hC, 1'b0, "pass"});
        vecs.push_back('{4'h9, 4'h0, 1'b0, 4'hD, 4'h2, 1'b1, "shl"});
        vecs.push_back('{4'h9, 4'h0, 1'b0, 4'hE, 4'h4, 1'b1, "shr"});

        // Reset held across an edge discards the operation; release then captures it.
        bus.Data_A_In           = 4'h5;
        bus.Data_B_In           = 4'h3;
        bus.Carry_Borrowb_In    = 1'b0;
        bus.Operation_Select_In = 4'h0;
        #1 rst = 1'b1;
        #1 check("reset_immediate", bus.Result_Out, bus.Carry_Out, 4'h0, 1'b0);
        @(negedge clk);
        check("reset_held_over_edge", bus.Result_Out, bus.Carry_Out, 4'h0, 1'b0);
        #2 rst = 1'b0;
        exp_q.push_back('{4'h8, 1'b0, "first_capture_after_reset"});
        capture();

        // Asynchronous reset between edges clears a live result at once.
        #1 rst = 1'b1;
        #1 check("async_reset_mid_cycle", bus.Result_Out, bus.Carry_Out, 4'h0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op,
                  vecs[i].r, vecs[i].c, vecs[i].name);
            capture();
        end

        // Back-to-back opcode changes: the previous result holds until the next edge.
        drive(4'hA, 4'h3, 1'b0, 4'h0, 4'hD, 1'b0, "b2b_add");
        capture();
        drive(4'hA, 4'h3, 1'b0, 4'h2, 4'h7, 1'b1, "b2b_sub");
        #1 check("hold_before_edge", bus.Result_Out, bus.Carry_Out, 4'hD, 1'b0);
        capture();

        for (int i = 0; i < 48; i++) begin
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rc  = 1'($urandom_range(0, 1));
            rop = 4'($urandom_range(0, 15));
            model(ra, rb, rc, rop, er, ec);
            drive(ra, rb, rc, rop, er, ec, $sformatf("rand%0d_op%h_a%h_b%h_c%b", i, rop, ra, rb, rc));
            if ($urandom_range(0, 4) == 0) begin
                #1 rst = 1'b1;
                #1 check("rand_reset_pulse", bus.Result_Out, bus.Carry_Out, 4'h0, 1'b0);
                rst = 1'b0;
            end
            capture();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
